hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the decode stage of the MIPS pipeline; multi-lane, multi-stage successor to the fixed execute/memory compare-and-stall logic.
- Tracks the newest in-flight producer of every GPR as it moves through post-decode stages.
- Per source operand, returns a forward-source select; per lane, returns a stall request.
- Sits beside decode. Consumes the issued bundle and pipeline-advance/flush controls. Drives forward muxes and the fetch/decode hold.

Parameters:
- LANES, 2, issue lanes per bundle (1..4).
- NSTAGE, 3, post-decode stages that can forward (1 = execute, 2 = memory, 3 = writeback).
- NREG, 32, architectural GPRs; register 0 is never tracked.
- KEEP_STAGE, 2, on flush, entries at stage >= KEEP_STAGE survive.
- STW, $clog2(NSTAGE+1), stage/select width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- advance  in  1  pipeline moves one stage this cycle
- flush  in  1  kill speculative in-flight producers
- issue_valid  in  LANES  lane l issues this cycle (recorded only when advance=1)
- issue_regw  in  LANES*5  destination register per lane (0 = no write)
- issue_rdy_stage  in  LANES*STW  first stage at which the lane's result is forwardable (ALU 1, load 2, mul 3)
- q_ra  in  LANES*2*5  source registers rs/rt per lane
- q_sel  out  LANES*2*STW  0 = regfile, k = forward from stage k
- q_stall  out  LANES  lane cannot issue this cycle
- busy  out  1  any entry valid

Behaviour:
- Storage:
  - Per register r (1..NREG-1): valid, stage[STW], rdy[STW].
  - All cleared asynchronously on reset; reset mid-operation drops all entries.
  - After reset, q_sel=0, q_stall=0, busy=0.
- Lookup (combinational, same cycle):
  - For operand (l,o): hit = q_ra != 0 && valid[q_ra].
  - Hit with stage >= rdy: q_sel = stage.
  - Hit with stage < rdy: q_sel = 0 and the operand is not-ready.
  - No hit: q_sel = 0.
- Stall rules:
  - q_stall[l] = any operand of lane l not-ready, OR an intra-bundle hazard, OR q_stall[l-1] (lanes issue in order).
  - Intra-bundle hazard: lane j < l has issue_valid, and issue_regw[j] != 0 equals a nonzero q_ra of lane l.
- Advance cycle (advance=1):
  - Every valid entry increments stage.
  - An entry at stage NSTAGE is cleared; its value is in the regfile, which is write-first.
  - Each lane with issue_valid && regw != 0 && !q_stall[l] writes entry regw: valid=1, stage=1, rdy=issue_rdy_stage.
  - The new entry overrides any existing or retiring entry for the same register.
  - Same regw on two lanes in one bundle: the higher lane index wins.
- Hold cycle (advance=0): stages frozen; no issue is recorded.
- Flush:
  - Entries with stage < KEEP_STAGE are cleared; the other entries still age if advance=1.
  - Issue in the same cycle as flush is ignored.
  - flush has priority over issue but not over reset.
- Latency: issue in cycle t with advance → entry at stage 1 in t+1 → forwardable from execute in t+1 if rdy=1.
- Load-use: a load (rdy=2) followed by a dependent instruction gives exactly one stall cycle (given advance). The dependent instruction then sees q_sel=2.
- issue_rdy_stage > NSTAGE is illegal; assertion only.
- busy = OR of all valid bits.

Decomposition:
- Shared package (pipeline package): creg_addr_t, fwd_sel_t (STW-bit), stage constants (STG_RF=0, STG_EXE=1, STG_MEM=2, STG_WB=3), lane-bundle issue struct {valid, regw, rdy_stage}.
- One sub-module, sb_entry: per-register valid/stage/rdy flops with age/clear/load logic. Instantiate NREG-1 times.
- Lookup and stall chain stay in the top level.

Test Plan:
1. ALU forward: lane0 issues addu $3 (rdy=1), advance; next cycle q_ra=$3 → q_sel=1, q_stall=0; one cycle later → q_sel=2; after exit from stage 3 → q_sel=0.
2. Load-use: lw $5 (rdy=2) issued, advance; dependent reads $5 → q_stall[0]=1; next advance cycle → q_stall=0, q_sel=2.
3. Intra-bundle: lane0 regw=$7, lane1 q_ra=$7 → q_stall[1]=1, q_stall[0]=0; lane1 alone issues next cycle with q_sel=1.
4. Override: $4 issued twice two cycles apart with rdy=1 then rdy=3 → the reader stalls while the newest entry has stage<3, and the older retirement does not clear $4.
5. Flush: entries at stages 1, 2, 3 for $8, $9, $10 plus flush with KEEP_STAGE=2 → $8 cleared; $9 moves to 3; $10 retires; issue in the same cycle is not recorded.
6. Reset mid-flight with three valid entries and advance=0 → busy=0 and all q_sel=0 immediately, without a clock edge; $0 as regw or q_ra never creates a stall.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef logic [REG_W-1:0] creg_addr_t;
  typedef logic [FWD_W-1:0] fwd_sel_t;

  // Post-decode stage numbering; 0 doubles as "read the register file".
  localparam fwd_sel_t STG_RF  = 2'd0;
  localparam fwd_sel_t STG_EXE = 2'd1;
  localparam fwd_sel_t STG_MEM = 2'd2;
  localparam fwd_sel_t STG_WB  = 2'd3;

  // One lane of an issued bundle.
  typedef struct packed {
    logic       valid;
    creg_addr_t regw;
    fwd_sel_t   rdy_stage;
  } issue_t;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// Per-register producer tracker: valid, current stage and forwardable-from stage.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned KEEP_STAGE = 2,
  parameter int unsigned STW        = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           advance,
  input  logic           flush,
  input  logic           load,
  input  logic [STW-1:0] load_rdy,
  output logic           valid,
  output logic [STW-1:0] stage,
  output logic [STW-1:0] rdy
);

  logic           valid_q, valid_d;
  logic [STW-1:0] stage_q, stage_d;
  logic [STW-1:0] rdy_q, rdy_d;

  // Next state: a new producer overrides everything; otherwise flush-kill, then age/retire.
  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    rdy_d   = rdy_q;
    if (load) begin
      valid_d = 1'b1;
      stage_d = STW'(STG_EXE);
      rdy_d   = load_rdy;
    end else if (valid_q) begin
      if (flush && (stage_q < STW'(KEEP_STAGE))) begin
        valid_d = 1'b0;
        stage_d = '0;
        rdy_d   = '0;
      end else if (advance) begin
        if (stage_q == STW'(NSTAGE)) begin
          // Leaving writeback: the write-first regfile now holds the value.
          valid_d = 1'b0;
          stage_d = '0;
          rdy_d   = '0;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      stage_q <= '0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
      rdy_q   <= rdy_d;
    end
  end

  assign valid = valid_q;
  assign stage = stage_q;
  assign rdy   = rdy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-lane register-hazard scoreboard: forward selects and in-order stall chain.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned NREG       = 32,
  parameter int unsigned KEEP_STAGE = 2,
  parameter int unsigned STW        = $clog2(NSTAGE + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     advance,
  input  logic                     flush,
  input  logic [LANES-1:0]         issue_valid,
  input  logic [LANES*5-1:0]       issue_regw,
  input  logic [LANES*STW-1:0]     issue_rdy_stage,
  input  logic [LANES*2*5-1:0]     q_ra,
  output logic [LANES*2*STW-1:0]   q_sel,
  output logic [LANES-1:0]         q_stall,
  output logic                     busy
);

  logic [NREG-1:0]          ent_valid;
  logic [NREG-1:0][STW-1:0] ent_stage;
  logic [NREG-1:0][STW-1:0] ent_rdy;
  logic [NREG-1:1]          ent_load;
  logic [NREG-1:1][STW-1:0] ent_load_rdy;
  logic [LANES*2-1:0]       op_pend;

  // $0 is hardwired; it never has a producer.
  assign ent_valid[0] = 1'b0;
  assign ent_stage[0] = '0;
  assign ent_rdy[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(
      .NSTAGE    (NSTAGE),
      .KEEP_STAGE(KEEP_STAGE),
      .STW       (STW)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .flush   (flush),
      .load    (ent_load[r]),
      .load_rdy(ent_load_rdy[r]),
      .valid   (ent_valid[r]),
      .stage   (ent_stage[r]),
      .rdy     (ent_rdy[r])
    );
  end

  // Operand lookup: forward once the producer reached its ready stage, else mark pending.
  always_comb begin
    q_sel   = '0;
    op_pend = '0;
    for (int op = 0; op < LANES * 2; op++) begin
      creg_addr_t ra;
      ra = q_ra[op*5 +: 5];
      if (ra != '0 && ent_valid[ra]) begin
        if (ent_stage[ra] >= ent_rdy[ra]) begin
          q_sel[op*STW +: STW] = ent_stage[ra];
        end else begin
          op_pend[op] = 1'b1;
        end
      end
    end
  end

  // Stall chain: own pending operand, older-lane write in the same bundle, or older stall.
  always_comb begin
    logic prev;
    q_stall = '0;
    prev    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      logic       st;
      creg_addr_t ra0, ra1, rw;
      ra0 = q_ra[(l*2)*5 +: 5];
      ra1 = q_ra[(l*2+1)*5 +: 5];
      st  = prev | op_pend[l*2] | op_pend[l*2+1];
      for (int j = 0; j < l; j++) begin
        rw = issue_regw[j*5 +: 5];
        if (issue_valid[j] && rw != '0 && (rw == ra0 || rw == ra1)) begin
          st = 1'b1;
        end
      end
      q_stall[l] = st;
      prev       = st;
    end
  end

  // Entry loads: ascending lane order so the highest issuing lane wins a shared regw.
  always_comb begin
    ent_load     = '0;
    ent_load_rdy = '0;
    if (advance && !flush) begin
      for (int l = 0; l < LANES; l++) begin
        if (issue_valid[l] && !q_stall[l]) begin
          for (int r = 1; r < NREG; r++) begin
            if (issue_regw[l*5 +: 5] == creg_addr_t'(r)) begin
              ent_load[r]     = 1'b1;
              ent_load_rdy[r] = issue_rdy_stage[l*STW +: STW];
            end
          end
        end
      end
    end
  end

  assign busy = |ent_valid;

`ifndef SYNTHESIS
  for (genvar l = 0; l < LANES; l++) begin : g_chk
    a_rdy_range : assert property (@(posedge clk) disable iff (reset)
      (advance && issue_valid[l]) |-> (issue_rdy_stage[l*STW +: STW] <= STW'(NSTAGE)));
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench: producer-list reference model, queued expectations.
module tb_hazard_scoreboard;

  localparam int LANES  = 2;
  localparam int NSTAGE = 3;
  localparam int NREG   = 32;
  localparam int KEEP   = 2;
  localparam int STW    = 2;

  logic                   clk = 1'b0;
  logic                   reset, advance, flush;
  logic [LANES-1:0]       issue_valid;
  logic [LANES*5-1:0]     issue_regw;
  logic [LANES*STW-1:0]   issue_rdy_stage;
  logic [LANES*10-1:0]    q_ra;
  logic [LANES*2*STW-1:0] q_sel;
  logic [LANES-1:0]       q_stall;
  logic                   busy;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .LANES     (LANES),
    .NSTAGE    (NSTAGE),
    .NREG      (NREG),
    .KEEP_STAGE(KEEP),
    .STW       (STW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .advance        (advance),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_regw     (issue_regw),
    .issue_rdy_stage(issue_rdy_stage),
    .q_ra           (q_ra),
    .q_sel          (q_sel),
    .q_stall        (q_stall),
    .busy           (busy)
  );

  // Expectation queues, filled by the driver and drained by the monitor.
  logic [LANES*2*STW-1:0] exp_sel[$];
  logic [LANES-1:0]       exp_stall[$];
  logic                   exp_busy[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: list of live producers, age derived from a global advance count.
  int pr_reg[$];
  int pr_birth[$];
  int pr_rdy[$];
  int adv_cnt = 0;

  // Inputs applied during the current cycle, consumed at the next rising edge.
  bit               a_rst = 1'b1;
  bit               a_adv, a_fl;
  logic [LANES-1:0] a_iv, a_stall;
  int               a_regw[LANES];
  int               a_rdy[LANES];

  function automatic int age(int i);
    return adv_cnt - pr_birth[i] + 1;
  endfunction

  function automatic int find(int r);
    for (int i = 0; i < pr_reg.size(); i++) if (pr_reg[i] == r) return i;
    return -1;
  endfunction

  task automatic del(int i);
    pr_reg.delete(i);
    pr_birth.delete(i);
    pr_rdy.delete(i);
  endtask

  task automatic model_clear();
    pr_reg.delete();
    pr_birth.delete();
    pr_rdy.delete();
  endtask

  task automatic model_edge();
    if (a_rst) begin
      model_clear();
      return;
    end
    if (a_fl) for (int i = pr_reg.size() - 1; i >= 0; i--) if (age(i) < KEEP) del(i);
    if (a_adv) begin
      adv_cnt++;
      for (int i = pr_reg.size() - 1; i >= 0; i--) if (age(i) > NSTAGE) del(i);
      if (!a_fl) begin
        for (int l = 0; l < LANES; l++) begin
          if (a_iv[l] && a_regw[l] != 0 && !a_stall[l]) begin
            int k;
            k = find(a_regw[l]);
            if (k >= 0) del(k);
            pr_reg.push_back(a_regw[l]);
            pr_birth.push_back(adv_cnt);
            pr_rdy.push_back(a_rdy[l]);
          end
        end
      end
    end
  endtask

  // One cycle: settle the model on the edge just passed, drive new inputs, queue expectation.
  task automatic step(input bit rst, input bit adv, input bit fl, input logic [LANES-1:0] iv,
                      input logic [LANES*5-1:0] rw, input logic [LANES*STW-1:0] rs,
                      input logic [LANES*10-1:0] ra);
    logic [LANES*2*STW-1:0] es;
    logic [LANES-1:0]       est;
    bit prev;
    @(posedge clk);
    #1;
    model_edge();
    reset = rst; advance = adv; flush = fl;
    issue_valid = iv; issue_regw = rw; issue_rdy_stage = rs; q_ra = ra;
    a_rst = rst; a_adv = adv; a_fl = fl; a_iv = iv;
    for (int l = 0; l < LANES; l++) begin
      a_regw[l] = int'(rw[l*5 +: 5]);
      a_rdy[l]  = int'(rs[l*STW +: STW]);
    end
    if (rst) model_clear();
    es = '0; est = '0; prev = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      bit st;
      int src[2];
      st = prev;
      for (int o = 0; o < 2; o++) begin
        src[o] = int'(ra[(l*2+o)*5 +: 5]);
        if (src[o] != 0) begin
          int k;
          k = find(src[o]);
          if (k >= 0) begin
            if (age(k) >= pr_rdy[k]) es[(l*2+o)*STW +: STW] = STW'(age(k));
            else st = 1'b1;
          end
        end
      end
      for (int j = 0; j < l; j++)
        if (iv[j] && a_regw[j] != 0 && (a_regw[j] == src[0] || a_regw[j] == src[1])) st = 1'b1;
      est[l] = st;
      prev = st;
    end
    a_stall = est;
    exp_sel.push_back(es);
    exp_stall.push_back(est);
    exp_busy.push_back(pr_reg.size() != 0);
  endtask

  // Monitor: outputs are combinational, so one expectation is presented per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_sel.size() > 0) begin
        logic [LANES*2*STW-1:0] es;
        logic [LANES-1:0]       est;
        logic                   eb;
        es = exp_sel.pop_front();
        est = exp_stall.pop_front();
        eb = exp_busy.pop_front();
        n_vec++;
        if (q_sel !== es) begin
          n_bad++;
          $display("FAIL q_sel @%0t: got %h want %h", $time, q_sel, es);
        end
        n_vec++;
        if (q_stall !== est) begin
          n_bad++;
          $display("FAIL q_stall @%0t: got %b want %b", $time, q_stall, est);
        end
        n_vec++;
        if (busy !== eb) begin
          n_bad++;
          $display("FAIL busy @%0t: got %b want %b", $time, busy, eb);
        end
      end
    end
  end

  // Pack helpers: lane0 in the low bits.
  function automatic logic [LANES*5-1:0] rw2(int l1, int l0);
    return {5'(l1), 5'(l0)};
  endfunction
  function automatic logic [LANES*10-1:0] ra4(int l1t, int l1s, int l0t, int l0s);
    return {5'(l1t), 5'(l1s), 5'(l0t), 5'(l0s)};
  endfunction

  initial begin
    reset = 1'b1; advance = 1'b0; flush = 1'b0;
    issue_valid = '0; issue_regw = '0; issue_rdy_stage = '0; q_ra = '0;
    step(1, 0, 0, 2'b00, '0, '0, '0);

    // ALU forward of $3 through EXE, MEM, WB, then back to regfile.
    step(0, 1, 0, 2'b01, rw2(0, 3), 4'b0001, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00, '0, '0, ra4(0, 0, 0, 3));

    // Load-use on $5: one stall, then forward from MEM.
    step(0, 1, 0, 2'b01, rw2(0, 5), 4'b0010, '0);
    step(0, 1, 0, 2'b01, rw2(0, 6), 4'b0001, ra4(0, 0, 0, 5));
    step(0, 1, 0, 2'b01, rw2(0, 6), 4'b0001, ra4(0, 0, 0, 5));

    // Intra-bundle: lane1 reads lane0's $7, then issues alone.
    step(0, 1, 0, 2'b11, rw2(11, 7), 4'b0101, ra4(0, 7, 0, 0));
    step(0, 1, 0, 2'b10, rw2(11, 0), 4'b0100, ra4(0, 7, 0, 0));

    // Override $4 (rdy 1, then rdy 3) with a reader behind it.
    step(0, 1, 0, 2'b01, rw2(0, 4), 4'b0001, '0);
    step(0, 1, 0, 2'b00, '0, '0, ra4(0, 0, 0, 4));
    step(0, 1, 0, 2'b01, rw2(0, 4), 4'b0011, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00, '0, '0, ra4(0, 0, 0, 4));

    // Flush with $10/$9/$8 at stages 3/2/1 and a same-cycle issue of $12.
    step(0, 1, 0, 2'b01, rw2(0, 10), 4'b0001, '0);
    step(0, 1, 0, 2'b01, rw2(0, 9), 4'b0001, '0);
    step(0, 1, 0, 2'b01, rw2(0, 8), 4'b0001, '0);
    step(0, 1, 1, 2'b01, rw2(0, 12), 4'b0001, ra4(9, 8, 0, 10));
    step(0, 1, 0, 2'b00, '0, '0, ra4(12, 9, 0, 8));

    // Mid-flight async reset while holding, with $0 as writer and reader.
    step(0, 1, 0, 2'b11, rw2(14, 13), 4'b1001, '0);
    step(0, 1, 0, 2'b01, rw2(0, 15), 4'b0001, ra4(0, 14, 0, 13));
    step(1, 0, 0, 2'b00, '0, '0, ra4(15, 14, 0, 13));
    step(0, 1, 0, 2'b11, rw2(0, 0), 4'b0101, ra4(0, 0, 0, 0));

    // Randomized traffic over a small register window to force hazards.
    for (int n = 0; n < 500; n++) begin
      logic [LANES*5-1:0]   rw;
      logic [LANES*STW-1:0] rs;
      logic [LANES*10-1:0]  ra;
      for (int l = 0; l < LANES; l++) begin
        rw[l*5 +: 5]     = 5'($urandom_range(0, 7));
        rs[l*STW +: STW] = STW'($urandom_range(1, NSTAGE));
      end
      for (int o = 0; o < LANES * 2; o++) ra[o*5 +: 5] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) == 0), LANES'($urandom), rw, rs, ra);
    end

    // Drain, bounded.
    for (int i = 0; i < 10 && exp_sel.size() > 0; i++) @(posedge clk);
    if (exp_sel.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_sel.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
